// File: rtl/aq_vfmau_retire_buf.sv
// ----------------------------------------------------------------------------
// aq_vfmau_retire_buf
//
// Retire buffer that sits directly behind the VFMAU pipeline control.
// Finished results arrive from three completion points: EX3 (short ops),
// EX4 (single-pass MAC / double ops) and EX5 (double MAC). They are queued
// in a small in-order circular FIFO. The FIFO presents them one per cycle to
// the VPU writeback port under a valid/ready handshake.
//
// Ports
//   forever_cpuclk          clock
//   cpurst                  asynchronous reset, active-high
//   vpu_vfmau_flush         synchronous flush, empties the buffer
//   exN_rslt_vld/data/fflags/vreg (N = 3,4,5)
//                           completion inputs from each stage
//   retire_exN_stall        stage N result not accepted this cycle
//   vfmau_vpu_wb_vld/data/fflags/vreg
//                           head-of-queue writeback outputs
//   vpu_vfmau_wb_ready      writeback port accepts the head entry
//   retire_buf_empty        no entries held
// ----------------------------------------------------------------------------
module aq_vfmau_retire_buf #(
    parameter int DEPTH       = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int FFLAG_WIDTH = 5,
    parameter int VREG_WIDTH  = 5
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst,
    input  logic                   vpu_vfmau_flush,
    input  logic                   ex3_rslt_vld,
    input  logic [DATA_WIDTH-1:0]  ex3_rslt_data,
    input  logic [FFLAG_WIDTH-1:0] ex3_rslt_fflags,
    input  logic [VREG_WIDTH-1:0]  ex3_rslt_vreg,
    input  logic                   ex4_rslt_vld,
    input  logic [DATA_WIDTH-1:0]  ex4_rslt_data,
    input  logic [FFLAG_WIDTH-1:0] ex4_rslt_fflags,
    input  logic [VREG_WIDTH-1:0]  ex4_rslt_vreg,
    input  logic                   ex5_rslt_vld,
    input  logic [DATA_WIDTH-1:0]  ex5_rslt_data,
    input  logic [FFLAG_WIDTH-1:0] ex5_rslt_fflags,
    input  logic [VREG_WIDTH-1:0]  ex5_rslt_vreg,
    output logic                   retire_ex3_stall,
    output logic                   retire_ex4_stall,
    output logic                   retire_ex5_stall,
    output logic                   vfmau_vpu_wb_vld,
    output logic [DATA_WIDTH-1:0]  vfmau_vpu_wb_data,
    output logic [FFLAG_WIDTH-1:0] vfmau_vpu_wb_fflags,
    output logic [VREG_WIDTH-1:0]  vfmau_vpu_wb_vreg,
    input  logic                   vpu_vfmau_wb_ready,
    output logic                   retire_buf_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [FFLAG_WIDTH-1:0] fflags;
        logic [VREG_WIDTH-1:0]  vreg;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   free_slots;
    logic               ex5_acc;
    logic               ex4_acc;
    logic               ex3_acc;
    logic [1:0]         older_acc;
    logic [1:0]         n_acc;
    logic [PTR_W-1:0]   ex4_idx;
    logic [PTR_W-1:0]   ex3_idx;
    logic               pop;

    // Slot allocation. Free space comes from the registered count only, so a
    // same-cycle pop never makes room. The oldest stage (EX5) is served first
    // and each younger stage takes a slot only if one remains after the older
    // stages. During a flush nothing is accepted and nothing is stalled.
    always_comb begin
        free_slots = CNT_W'(DEPTH) - cnt;
        ex5_acc    = ex5_rslt_vld && !vpu_vfmau_flush && (free_slots != '0);
        ex4_acc    = ex4_rslt_vld && !vpu_vfmau_flush
                     && (free_slots > CNT_W'(ex5_acc));
        older_acc  = {1'b0, ex5_acc} + {1'b0, ex4_acc};
        ex3_acc    = ex3_rslt_vld && !vpu_vfmau_flush
                     && (free_slots > CNT_W'(older_acc));
        n_acc      = older_acc + {1'b0, ex3_acc};
        ex4_idx    = wr_ptr + PTR_W'(ex5_acc);
        ex3_idx    = wr_ptr + PTR_W'(older_acc);
    end

    assign retire_ex5_stall = ex5_rslt_vld && !ex5_acc && !vpu_vfmau_flush;
    assign retire_ex4_stall = ex4_rslt_vld && !ex4_acc && !vpu_vfmau_flush;
    assign retire_ex3_stall = ex3_rslt_vld && !ex3_acc && !vpu_vfmau_flush;

    assign pop = vfmau_vpu_wb_vld && vpu_vfmau_wb_ready;

    // Pointer and count state. A flush wins over any push or pop. A pop that
    // lands in the flush cycle is still a completed handshake for the consumer.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (vpu_vfmau_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_acc);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            cnt    <= cnt + CNT_W'(n_acc) - CNT_W'(pop);
        end
    end

    // Payload storage is not reset. Accepted results are written to
    // consecutive slots in age order, so the three indices never collide.
    always_ff @(posedge forever_cpuclk) begin
        if (ex5_acc) mem[wr_ptr]  <= '{ex5_rslt_data, ex5_rslt_fflags, ex5_rslt_vreg};
        if (ex4_acc) mem[ex4_idx] <= '{ex4_rslt_data, ex4_rslt_fflags, ex4_rslt_vreg};
        if (ex3_acc) mem[ex3_idx] <= '{ex3_rslt_data, ex3_rslt_fflags, ex3_rslt_vreg};
    end

    // The head outputs come from registered state only, so there is no bypass.
    // They follow an asynchronous reset at once because they derive from cnt.
    assign vfmau_vpu_wb_vld    = (cnt != '0);
    assign retire_buf_empty    = (cnt == '0);
    assign vfmau_vpu_wb_data   = mem[rd_ptr].data;
    assign vfmau_vpu_wb_fflags = mem[rd_ptr].fflags;
    assign vfmau_vpu_wb_vreg   = mem[rd_ptr].vreg;

endmodule

// File: tb/tb_aq_vfmau_retire_buf.sv
// ----------------------------------------------------------------------------
// tb_aq_vfmau_retire_buf
//
// Directed bench for aq_vfmau_retire_buf (DEPTH=4). A table of per-cycle
// vectors covers ordering, full-buffer stalls, push/pop overlap and flush.
// Hand-written sequences cover the single EX3 result, back-pressure hold,
// wrap-around with random ready, and an asynchronous mid-burst reset.
// ----------------------------------------------------------------------------
module tb_aq_vfmau_retire_buf;

    logic        forever_cpuclk;
    logic        cpurst;
    logic        vpu_vfmau_flush;
    logic        ex3_rslt_vld, ex4_rslt_vld, ex5_rslt_vld;
    logic [63:0] ex3_rslt_data, ex4_rslt_data, ex5_rslt_data;
    logic [4:0]  ex3_rslt_fflags, ex4_rslt_fflags, ex5_rslt_fflags;
    logic [4:0]  ex3_rslt_vreg, ex4_rslt_vreg, ex5_rslt_vreg;
    logic        retire_ex3_stall, retire_ex4_stall, retire_ex5_stall;
    logic        vfmau_vpu_wb_vld;
    logic [63:0] vfmau_vpu_wb_data;
    logic [4:0]  vfmau_vpu_wb_fflags;
    logic [4:0]  vfmau_vpu_wb_vreg;
    logic        vpu_vfmau_wb_ready;
    logic        retire_buf_empty;

    int errors = 0;
    int checks = 0;

    aq_vfmau_retire_buf #(
        .DEPTH(4), .DATA_WIDTH(64), .FFLAG_WIDTH(5), .VREG_WIDTH(5)
    ) dut (
        .forever_cpuclk      (forever_cpuclk),
        .cpurst              (cpurst),
        .vpu_vfmau_flush     (vpu_vfmau_flush),
        .ex3_rslt_vld        (ex3_rslt_vld),
        .ex3_rslt_data       (ex3_rslt_data),
        .ex3_rslt_fflags     (ex3_rslt_fflags),
        .ex3_rslt_vreg       (ex3_rslt_vreg),
        .ex4_rslt_vld        (ex4_rslt_vld),
        .ex4_rslt_data       (ex4_rslt_data),
        .ex4_rslt_fflags     (ex4_rslt_fflags),
        .ex4_rslt_vreg       (ex4_rslt_vreg),
        .ex5_rslt_vld        (ex5_rslt_vld),
        .ex5_rslt_data       (ex5_rslt_data),
        .ex5_rslt_fflags     (ex5_rslt_fflags),
        .ex5_rslt_vreg       (ex5_rslt_vreg),
        .retire_ex3_stall    (retire_ex3_stall),
        .retire_ex4_stall    (retire_ex4_stall),
        .retire_ex5_stall    (retire_ex5_stall),
        .vfmau_vpu_wb_vld    (vfmau_vpu_wb_vld),
        .vfmau_vpu_wb_data   (vfmau_vpu_wb_data),
        .vfmau_vpu_wb_fflags (vfmau_vpu_wb_fflags),
        .vfmau_vpu_wb_vreg   (vfmau_vpu_wb_vreg),
        .vpu_vfmau_wb_ready  (vpu_vfmau_wb_ready),
        .retire_buf_empty    (retire_buf_empty)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    // One table row is one clock cycle. It holds the inputs driven in that
    // cycle and the outputs expected before the next rising edge.
    typedef struct packed {
        logic       flush;
        logic       ready;
        logic       v5;
        logic [4:0] r5;
        logic       v4;
        logic [4:0] r4;
        logic       v3;
        logic [4:0] r3;
        logic       s5;
        logic       s4;
        logic       s3;
        logic       vld;
        logic [4:0] vreg;
        logic       empty;
    } vec_t;

    localparam int NVEC = 33;
    vec_t vecs [NVEC];

    function automatic vec_t mkv(input logic fl, input logic rd,
                                 input logic v5, input int r5,
                                 input logic v4, input int r4,
                                 input logic v3, input int r3,
                                 input logic s5, input logic s4, input logic s3,
                                 input logic vld, input int vreg, input logic empty);
        vec_t v;
        v.flush = fl;  v.ready = rd;
        v.v5 = v5;     v.r5 = 5'(r5);
        v.v4 = v4;     v.r4 = 5'(r4);
        v.v3 = v3;     v.r3 = 5'(r3);
        v.s5 = s5;     v.s4 = s4;     v.s3 = s3;
        v.vld = vld;   v.vreg = 5'(vreg); v.empty = empty;
        return v;
    endfunction

    // Payload fields are derived from the destination so that data and flags
    // can be checked against the expected vreg.
    function automatic logic [63:0] mkData(input logic [4:0] r);
        return {32'hA5A5_5A5A, 27'd0, r};
    endfunction

    function automatic logic [4:0] mkFlags(input logic [4:0] r);
        return r ^ 5'h15;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        vpu_vfmau_flush    = 1'b0;
        vpu_vfmau_wb_ready = 1'b0;
        ex5_rslt_vld = 1'b0; ex5_rslt_data = '0; ex5_rslt_fflags = '0; ex5_rslt_vreg = '0;
        ex4_rslt_vld = 1'b0; ex4_rslt_data = '0; ex4_rslt_fflags = '0; ex4_rslt_vreg = '0;
        ex3_rslt_vld = 1'b0; ex3_rslt_data = '0; ex3_rslt_fflags = '0; ex3_rslt_vreg = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        vpu_vfmau_flush    = v.flush;
        vpu_vfmau_wb_ready = v.ready;
        ex5_rslt_vld = v.v5; ex5_rslt_vreg = v.r5; ex5_rslt_data = mkData(v.r5); ex5_rslt_fflags = mkFlags(v.r5);
        ex4_rslt_vld = v.v4; ex4_rslt_vreg = v.r4; ex4_rslt_data = mkData(v.r4); ex4_rslt_fflags = mkFlags(v.r4);
        ex3_rslt_vld = v.v3; ex3_rslt_vreg = v.r3; ex3_rslt_data = mkData(v.r3); ex3_rslt_fflags = mkFlags(v.r3);
    endtask

    initial begin
        // Fields: flush, ready, v5,r5, v4,r4, v3,r3, s5,s4,s3, vld,vreg, empty
        vecs[0]  = mkv(0,0, 0,0,  0,0,  0,0,  0,0,0, 0,0,  1);
        // Triple completion into an empty buffer, then retire in age order
        vecs[1]  = mkv(0,1, 1,1,  1,2,  1,3,  0,0,0, 0,0,  1);
        vecs[2]  = mkv(0,1, 0,0,  0,0,  0,0,  0,0,0, 1,1,  0);
        vecs[3]  = mkv(0,1, 0,0,  0,0,  0,0,  0,0,0, 1,2,  0);
        vecs[4]  = mkv(0,1, 0,0,  0,0,  0,0,  0,0,0, 1,3,  0);
        vecs[5]  = mkv(0,1, 0,0,  0,0,  0,0,  0,0,0, 0,0,  1);
        // Fill to four with ready low, then EX4+EX3 both stall
        vecs[6]  = mkv(0,0, 1,4,  1,5,  1,6,  0,0,0, 0,0,  1);
        vecs[7]  = mkv(0,0, 0,0,  0,0,  1,7,  0,0,0, 1,4,  0);
        vecs[8]  = mkv(0,0, 0,0,  1,8,  1,9,  0,1,1, 1,4,  0);
        // Pop while full still frees nothing this cycle
        vecs[9]  = mkv(0,1, 0,0,  1,8,  1,9,  0,1,1, 1,4,  0);
        // One slot now free: EX4 wins over EX3
        vecs[10] = mkv(0,0, 0,0,  1,8,  1,9,  0,0,1, 1,5,  0);
        // Full again: EX5 and EX3 both stall
        vecs[11] = mkv(0,0, 1,10, 0,0,  1,9,  1,0,1, 1,5,  0);
        vecs[12] = mkv(0,1, 1,10, 0,0,  1,9,  1,0,1, 1,5,  0);
        // One slot: EX5 wins over EX3, with simultaneous pop
        vecs[13] = mkv(0,1, 1,10, 0,0,  1,9,  0,0,1, 1,6,  0);
        vecs[14] = mkv(0,1, 0,0,  0,0,  1,9,  0,0,0, 1,7,  0);
        vecs[15] = mkv(0,1, 0,0,  0,0,  0,0,  0,0,0, 1,8,  0);
        vecs[16] = mkv(0,1, 0,0,  0,0,  0,0,  0,0,0, 1,10, 0);
        vecs[17] = mkv(0,1, 0,0,  0,0,  0,0,  0,0,0, 1,9,  0);
        vecs[18] = mkv(0,1, 0,0,  0,0,  0,0,  0,0,0, 0,0,  1);
        // Push and pop in the same cycle
        vecs[19] = mkv(0,1, 0,0,  0,0,  1,11, 0,0,0, 0,0,  1);
        vecs[20] = mkv(0,1, 0,0,  1,12, 0,0,  0,0,0, 1,11, 0);
        vecs[21] = mkv(0,1, 0,0,  0,0,  0,0,  0,0,0, 1,12, 0);
        vecs[22] = mkv(0,0, 0,0,  0,0,  0,0,  0,0,0, 0,0,  1);
        // Three queued, flush with a new EX3 push: discarded
        vecs[23] = mkv(0,0, 1,13, 1,14, 1,15, 0,0,0, 0,0,  1);
        vecs[24] = mkv(1,0, 0,0,  0,0,  1,16, 0,0,0, 1,13, 0);
        vecs[25] = mkv(0,0, 0,0,  0,0,  0,0,  0,0,0, 0,0,  1);
        // Full with a stalled stage, then flush: stalls forced low
        vecs[26] = mkv(0,0, 1,20, 1,21, 1,22, 0,0,0, 0,0,  1);
        vecs[27] = mkv(0,0, 1,23, 1,24, 0,0,  0,1,0, 1,20, 0);
        vecs[28] = mkv(1,1, 0,0,  1,24, 1,25, 0,0,0, 1,20, 0);
        vecs[29] = mkv(0,1, 0,0,  0,0,  0,0,  0,0,0, 0,0,  1);
        // Pointers restart at zero after flush
        vecs[30] = mkv(0,1, 0,0,  0,0,  1,26, 0,0,0, 0,0,  1);
        vecs[31] = mkv(0,1, 0,0,  0,0,  0,0,  0,0,0, 1,26, 0);
        vecs[32] = mkv(0,0, 0,0,  0,0,  0,0,  0,0,0, 0,0,  1);
    end

    // Main sequence. Inputs change 1 ns after a rising edge and outputs are
    // sampled on the falling edge.
    initial begin
        int  in_idx;
        int  out_idx;
        int  cyc;
        logic acc;
        logic [4:0] held_vreg;
        logic [63:0] held_data;

        idleInputs();
        cpurst = 1'b1;

        // Reset state
        @(negedge forever_cpuclk);
        checkOutput("rst_vld",   64'(vfmau_vpu_wb_vld), 64'd0);
        checkOutput("rst_empty", 64'(retire_buf_empty), 64'd1);
        checkOutput("rst_stall", 64'({retire_ex5_stall, retire_ex4_stall, retire_ex3_stall}), 64'd0);
        @(negedge forever_cpuclk);
        cpurst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            @(posedge forever_cpuclk);
            #1;
            applyStimulus(vecs[i]);
            @(negedge forever_cpuclk);
            checkOutput($sformatf("vec%0d_s5", i),    64'(retire_ex5_stall), 64'(vecs[i].s5));
            checkOutput($sformatf("vec%0d_s4", i),    64'(retire_ex4_stall), 64'(vecs[i].s4));
            checkOutput($sformatf("vec%0d_s3", i),    64'(retire_ex3_stall), 64'(vecs[i].s3));
            checkOutput($sformatf("vec%0d_vld", i),   64'(vfmau_vpu_wb_vld), 64'(vecs[i].vld));
            checkOutput($sformatf("vec%0d_empty", i), 64'(retire_buf_empty), 64'(vecs[i].empty));
            if (vecs[i].vld) begin
                checkOutput($sformatf("vec%0d_vreg", i),  64'(vfmau_vpu_wb_vreg),   64'(vecs[i].vreg));
                checkOutput($sformatf("vec%0d_data", i),  vfmau_vpu_wb_data,        mkData(vecs[i].vreg));
                checkOutput($sformatf("vec%0d_flags", i), 64'(vfmau_vpu_wb_fflags), 64'(mkFlags(vecs[i].vreg)));
            end
        end

        // Single EX3 result with ready high: visible for exactly one cycle
        @(posedge forever_cpuclk);
        #1;
        idleInputs();
        vpu_vfmau_wb_ready = 1'b1;
        ex3_rslt_vld    = 1'b1;
        ex3_rslt_data   = 64'h3FF0_0000_0000_0000;
        ex3_rslt_fflags = 5'h00;
        ex3_rslt_vreg   = 5'd5;
        @(negedge forever_cpuclk);
        checkOutput("single_stall_t", 64'(retire_ex3_stall), 64'd0);
        checkOutput("single_vld_t",   64'(vfmau_vpu_wb_vld), 64'd0);
        @(posedge forever_cpuclk);
        #1;
        ex3_rslt_vld = 1'b0;
        @(negedge forever_cpuclk);
        checkOutput("single_vld_t1",  64'(vfmau_vpu_wb_vld),  64'd1);
        checkOutput("single_data_t1", vfmau_vpu_wb_data,      64'h3FF0_0000_0000_0000);
        checkOutput("single_vreg_t1", 64'(vfmau_vpu_wb_vreg), 64'd5);
        @(posedge forever_cpuclk);
        #1;
        @(negedge forever_cpuclk);
        checkOutput("single_vld_t2",   64'(vfmau_vpu_wb_vld), 64'd0);
        checkOutput("single_empty_t2", 64'(retire_buf_empty), 64'd1);

        // Back-pressure hold: one entry queued, ready low for five cycles
        @(posedge forever_cpuclk);
        #1;
        idleInputs();
        ex4_rslt_vld = 1'b1; ex4_rslt_vreg = 5'd17;
        ex4_rslt_data = mkData(5'd17); ex4_rslt_fflags = mkFlags(5'd17);
        @(posedge forever_cpuclk);
        #1;
        ex4_rslt_vld = 1'b0;
        held_vreg = 5'd17;
        held_data = mkData(5'd17);
        for (int k = 0; k < 5; k++) begin
            @(negedge forever_cpuclk);
            checkOutput($sformatf("hold%0d_vld", k),  64'(vfmau_vpu_wb_vld),  64'd1);
            checkOutput($sformatf("hold%0d_vreg", k), 64'(vfmau_vpu_wb_vreg), 64'(held_vreg));
            checkOutput($sformatf("hold%0d_data", k), vfmau_vpu_wb_data,      held_data);
            @(posedge forever_cpuclk);
            #1;
        end
        vpu_vfmau_wb_ready = 1'b1;
        @(posedge forever_cpuclk);
        #1;
        vpu_vfmau_wb_ready = 1'b0;
        @(negedge forever_cpuclk);
        checkOutput("hold_drained", 64'(retire_buf_empty), 64'd1);

        // Wrap-around: ten sequential EX3 results with random ready
        in_idx  = 0;
        out_idx = 0;
        cyc     = 0;
        while (out_idx < 10 && cyc < 400) begin
            @(posedge forever_cpuclk);
            #1;
            ex3_rslt_vld       = (in_idx < 10);
            ex3_rslt_vreg      = 5'(in_idx);
            ex3_rslt_data      = mkData(5'(in_idx));
            ex3_rslt_fflags    = mkFlags(5'(in_idx));
            vpu_vfmau_wb_ready = 1'($urandom_range(0, 1));
            @(negedge forever_cpuclk);
            acc = ex3_rslt_vld && !retire_ex3_stall;
            if (vfmau_vpu_wb_vld && vpu_vfmau_wb_ready) begin
                checkOutput($sformatf("wrap_out%0d", out_idx), 64'(vfmau_vpu_wb_vreg), 64'(out_idx));
                out_idx++;
            end
            if (acc) in_idx++;
            cyc++;
        end
        checkOutput("wrap_count", 64'(out_idx), 64'd10);
        @(posedge forever_cpuclk);
        #1;
        idleInputs();
        @(negedge forever_cpuclk);
        checkOutput("wrap_empty", 64'(retire_buf_empty), 64'd1);

        // Asynchronous reset in the middle of a burst
        @(posedge forever_cpuclk);
        #1;
        ex5_rslt_vld = 1'b1; ex5_rslt_vreg = 5'd1; ex5_rslt_data = mkData(5'd1);
        ex4_rslt_vld = 1'b1; ex4_rslt_vreg = 5'd2; ex4_rslt_data = mkData(5'd2);
        @(posedge forever_cpuclk);
        #1;
        ex5_rslt_vld = 1'b0;
        ex4_rslt_vld = 1'b0;
        ex3_rslt_vld = 1'b1; ex3_rslt_vreg = 5'd3; ex3_rslt_data = mkData(5'd3);
        @(negedge forever_cpuclk);
        checkOutput("arst_pre_vld", 64'(vfmau_vpu_wb_vld), 64'd1);
        #2;
        cpurst = 1'b1;
        #1;
        checkOutput("arst_vld",   64'(vfmau_vpu_wb_vld), 64'd0);
        checkOutput("arst_empty", 64'(retire_buf_empty), 64'd1);
        checkOutput("arst_stall", 64'({retire_ex5_stall, retire_ex4_stall, retire_ex3_stall}), 64'd0);
        idleInputs();
        @(negedge forever_cpuclk);
        cpurst = 1'b0;
        @(negedge forever_cpuclk);
        checkOutput("post_rst_empty", 64'(retire_buf_empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/aq_vfmau_retire_buf.md
Name: aq_vfmau_retire_buf

Overview:
- Result retire buffer directly downstream of the VFMAU pipeline control.
- Accepts finished results from three completion points:
  - EX3: short ops, signalled by the EX2 result-ready-in-EX3 condition.
  - EX4: single-pass MAC or double ops, signalled by the EX3 result-ready-in-EX4 condition.
  - EX5: double MAC.
- Queues results in a small in-order FIFO and presents them one per cycle to the VPU writeback port under a valid/ready handshake.
- Back-pressures any completion stage it cannot absorb with a per-stage stall.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..8.
- DATA_WIDTH, 64, result data width.
- FFLAG_WIDTH, 5, floating-point exception flags width.
- VREG_WIDTH, 5, destination register index width.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst  in  1  asynchronous reset, active-high.
- vpu_vfmau_flush  in  1  synchronous pipeline flush; empties the buffer.
- ex3_rslt_vld  in  1  EX3 completion valid.
- ex3_rslt_data  in  DATA_WIDTH  EX3 result.
- ex3_rslt_fflags  in  FFLAG_WIDTH  EX3 flags.
- ex3_rslt_vreg  in  VREG_WIDTH  EX3 destination.
- ex4_rslt_vld/data/fflags/vreg  in  1/DATA_WIDTH/FFLAG_WIDTH/VREG_WIDTH  EX4 completion.
- ex5_rslt_vld/data/fflags/vreg  in  1/DATA_WIDTH/FFLAG_WIDTH/VREG_WIDTH  EX5 completion.
- retire_ex3_stall  out  1  EX3 result not accepted this cycle.
- retire_ex4_stall  out  1  EX4 result not accepted this cycle.
- retire_ex5_stall  out  1  EX5 result not accepted this cycle.
- vfmau_vpu_wb_vld  out  1  head entry valid.
- vfmau_vpu_wb_data  out  DATA_WIDTH  head data.
- vfmau_vpu_wb_fflags  out  FFLAG_WIDTH  head flags.
- vfmau_vpu_wb_vreg  out  VREG_WIDTH  head destination.
- vpu_vfmau_wb_ready  in  1  writeback port accepts head.
- retire_buf_empty  out  1  no entries held; used for drain/idle.

Behaviour:
- Storage:
  - DEPTH-entry circular FIFO.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - cnt is log2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (cpurst high, asynchronous):
  - wr_ptr=0, rd_ptr=0, cnt=0.
  - vfmau_vpu_wb_vld=0, retire_buf_empty=1, all stalls=0.
  - Entry payloads are not reset.
- Acceptance (combinational, per cycle):
  - free = DEPTH - cnt, using the registered cnt. A pop in the same cycle does NOT create a free slot.
  - Requesting stages are served oldest-first: EX5, then EX4, then EX3. Each valid stage takes the next free slot while free > 0.
  - Accepted entries are written at consecutive wr_ptr positions in that order: EX5 at wr_ptr, next at wr_ptr+1, and so on, all modulo DEPTH.
  - retire_exN_stall = exN_rslt_vld && !exN_accepted. It is purely combinational and never set when the stage's vld is 0.
  - A stalled stage holds vld and payload stable. The block re-evaluates every cycle and keeps no memory of a stall.
- Pop:
  - pop = vfmau_vpu_wb_vld && vpu_vfmau_wb_ready.
  - On pop, rd_ptr advances by 1 (wraps).
  - vfmau_vpu_wb_vld = (cnt != 0). Head outputs are driven from entry[rd_ptr].
  - Payload is stable while vld=1 and ready=0.
- Count update: cnt_next = cnt + n_accepted - pop, where n_accepted is 0..3. It never exceeds DEPTH and never goes negative.
- Latency: a result accepted in cycle t is visible on vfmau_vpu_wb_* no earlier than cycle t+1. There is no combinational bypass.
- Simultaneous events:
  - Push and pop in the same cycle are both performed.
  - Full (cnt=DEPTH) with pop: still no acceptance that cycle, and all valid stages stall.
- Flush:
  - vpu_vfmau_flush=1 overrides everything: next-cycle cnt=0, wr_ptr=rd_ptr=0.
  - Same-cycle pushes are discarded.
  - All stall outputs are 0 during flush, because the stages are being killed.
  - A pop in the flush cycle is still reported to the consumer; the handshake is honoured and the entry is treated as retired.
- Reset mid-operation: all queued results are lost and the outputs return to their reset values immediately, asynchronously.

Test Plan:
- Single EX3 result:
  - Stimulus: data=0x3FF0_0000_0000_0000, vreg=5, with ready=1.
  - Required: wb_vld=1 for exactly one cycle, at t+1, with matching payload; cnt returns to 0; no stalls.
- Triple same-cycle completion into an empty buffer:
  - Stimulus: EX5 A, EX4 B and EX3 C all valid in the same cycle, with ready=1.
  - Required: retire order A, B, C on consecutive cycles t+1..t+3; stalls stay 0.
- Full buffer and stall ordering:
  - Stimulus: ready=0; fill 4 entries; then present EX4 and EX3 together.
  - Required: retire_ex4_stall=1 and retire_ex3_stall=1.
  - Then raise ready for one cycle: both stalls remain 1 that cycle (pop frees no slot).
  - Next cycle: EX4 accepted and retire_ex3_stall=1.
- Wrap-around:
  - Stimulus: push/pop 10 sequential results with vreg=0..9, with random ready.
  - Required: output order 0..9 with no loss or duplication; wr_ptr and rd_ptr wrap at 4.
- Back-pressure hold:
  - Stimulus: hold ready=0 for 5 cycles with one entry queued.
  - Required: wb_vld and the payload stay constant across all 5 cycles.
- Flush and reset:
  - Stimulus: with 3 entries queued, assert vpu_vfmau_flush together with a new EX3 push.
  - Required next cycle: wb_vld=0 and retire_buf_empty=1.
  - Stimulus: assert cpurst asynchronously mid-burst.
  - Required: wb_vld drops immediately, without waiting for a clock edge.
